// File: rtl/dcm_select_ctrl_if.sv
// Lock inputs and clock-mux control outputs of the two-DCM clock-source controller.
// The controller takes the slave side; the DCM/mux environment takes the master side.
interface dcm_select_ctrl_if;
  logic       locked_f1;
  logic       locked_f2;
  logic       f_select;
  logic       clk_en;
  logic       src_valid;
  logic       dcm_rst_f1;
  logic       dcm_rst_f2;
  logic [7:0] switch_cnt;

  modport master (
    output locked_f1, locked_f2,
    input  f_select, clk_en, src_valid, dcm_rst_f1, dcm_rst_f2, switch_cnt
  );

  modport slave (
    input  locked_f1, locked_f2,
    output f_select, clk_en, src_valid, dcm_rst_f1, dcm_rst_f2, switch_cnt
  );
endinterface

// File: rtl/dcm_select_ctrl.sv
// Sequenced f1/f2 clock-source controller: filtered DCM lock detection, gapped
// glitch-free mux switchover (f2 preferred) and DCM reset retry on long lock loss.
module dcm_select_ctrl #(
  parameter int FILT_LEN    = 16,
  parameter int GAP_LEN     = 8,
  parameter int RST_TIMEOUT = 1024,
  parameter int RST_PULSE   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  dcm_select_ctrl_if.slave bus
);
  localparam int FILT_W  = $clog2(FILT_LEN + 1);
  localparam int GAP_W   = $clog2(GAP_LEN + 1);
  localparam int TO_W    = $clog2(RST_TIMEOUT + 1);
  localparam int PULSE_W = $clog2(RST_PULSE + 1);

  typedef enum logic [1:0] {NOSRC, RUN, DRAIN, SETTLE} state_t;

  // Channel index 0 = f1, 1 = f2, which matches the f_select encoding.
  logic [1:0] sync_meta, sync_q;
  logic [1:0] good;
  logic [1:0] dcm_rst;

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= {bus.locked_f2, bus.locked_f1};
      sync_q    <= sync_meta;
    end
  end

  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    logic [FILT_W-1:0]  filt_cnt;
    logic [TO_W-1:0]    unlock_cnt;
    logic [PULSE_W-1:0] pulse_cnt;
    logic               rst_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        filt_cnt   <= '0;
        unlock_cnt <= '0;
        pulse_cnt  <= '0;
        rst_q      <= 1'b0;
      end else begin
        if (!sync_q[ch])
          filt_cnt <= '0;
        else if (filt_cnt != FILT_W'(FILT_LEN))
          filt_cnt <= filt_cnt + FILT_W'(1);

        // A running pulse always completes; a returning lock only clears the timeout.
        if (rst_q) begin
          if (pulse_cnt == PULSE_W'(RST_PULSE - 1)) begin
            rst_q     <= 1'b0;
            pulse_cnt <= '0;
          end else begin
            pulse_cnt <= pulse_cnt + PULSE_W'(1);
          end
        end

        if (sync_q[ch]) begin
          unlock_cnt <= '0;
        end else if (!rst_q) begin
          if (unlock_cnt == TO_W'(RST_TIMEOUT - 1)) begin
            unlock_cnt <= '0;
            rst_q      <= 1'b1;
          end else begin
            unlock_cnt <= unlock_cnt + TO_W'(1);
          end
        end
      end
    end

    assign good[ch]    = (filt_cnt == FILT_W'(FILT_LEN));
    assign dcm_rst[ch] = rst_q;
  end

  logic has_tgt, tgt;
  assign has_tgt = |good;
  assign tgt     = good[1];

  state_t           state;
  logic [GAP_W-1:0] gap_cnt;
  logic             pend_sel;
  logic             f_select;
  logic             clk_en;
  logic [7:0]       switch_cnt;
  logic             gap_done;

  assign gap_done = (gap_cnt == GAP_W'(GAP_LEN - 1));

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // f_select only moves on entry to SETTLE, and clk_en is already low there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= NOSRC;
      gap_cnt    <= '0;
      pend_sel   <= 1'b0;
      f_select   <= 1'b0;
      clk_en     <= 1'b0;
      switch_cnt <= '0;
    end else begin
      case (state)
        NOSRC: begin
          if (has_tgt) begin
            f_select <= tgt;
            if (tgt != f_select) switch_cnt <= sat_inc(switch_cnt);
            gap_cnt  <= '0;
            state    <= SETTLE;
          end
        end
        RUN: begin
          if (!good[f_select] && !has_tgt) begin
            clk_en <= 1'b0;
            state  <= NOSRC;
          end else if (has_tgt && tgt != f_select) begin
            pend_sel <= tgt;
            clk_en   <= 1'b0;
            gap_cnt  <= '0;
            state    <= DRAIN;
          end
        end
        DRAIN: begin
          if (gap_done) begin
            f_select <= pend_sel;
            if (pend_sel != f_select) switch_cnt <= sat_inc(switch_cnt);
            gap_cnt  <= '0;
            state    <= SETTLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        SETTLE: begin
          if (gap_done) begin
            gap_cnt <= '0;
            if (good[f_select]) begin
              clk_en <= 1'b1;
              state  <= RUN;
            end else if (has_tgt) begin
              pend_sel <= tgt;
              state    <= DRAIN;
            end else begin
              state <= NOSRC;
            end
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: state <= NOSRC;
      endcase
    end
  end

  assign bus.f_select   = f_select;
  assign bus.clk_en     = clk_en;
  assign bus.src_valid  = clk_en;
  assign bus.dcm_rst_f1 = dcm_rst[0];
  assign bus.dcm_rst_f2 = dcm_rst[1];
  assign bus.switch_cnt = switch_cnt;
endmodule

// File: tb/tb_dcm_select_ctrl.sv
// Bench for dcm_select_ctrl: directed lock waveforms, a run-length/deadline model
// compared every cycle, and hand-computed timing points from reset release.
module tb_dcm_select_ctrl;
  localparam int FILT_LEN    = 16;
  localparam int GAP_LEN     = 8;
  localparam int RST_TIMEOUT = 1024;
  localparam int RST_PULSE   = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  dcm_select_ctrl_if bus ();

  dcm_select_ctrl #(
    .FILT_LEN   (FILT_LEN),
    .GAP_LEN    (GAP_LEN),
    .RST_TIMEOUT(RST_TIMEOUT),
    .RST_PULSE  (RST_PULSE)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_NOSRC, M_RUN, M_DRAIN, M_SETTLE} mmode_t;
  mmode_t   m_mode = M_NOSRC;
  int       m_cyc  = 0;
  int       m_due  = 0;
  bit       m_sel  = 1'b0;
  bit       m_next = 1'b0;
  int       m_cnt  = 0;
  bit [1:0] m_hist [2];
  int       m_high_run [2];
  int       m_low_run [2];
  int       m_pulse_left [2];
  bit       m_good [2];

  task automatic model_reset();
    m_mode = M_NOSRC;
    m_cyc  = 0;
    m_due  = 0;
    m_sel  = 1'b0;
    m_next = 1'b0;
    m_cnt  = 0;
    for (int ch = 0; ch < 2; ch++) begin
      m_hist[ch]       = '0;
      m_high_run[ch]   = 0;
      m_low_run[ch]    = 0;
      m_pulse_left[ch] = 0;
      m_good[ch]       = 1'b0;
    end
  endtask

  task automatic move_sel(input bit v);
    if (v != m_sel && m_cnt < 255) m_cnt++;
    m_sel = v;
  endtask

  task automatic model_step();
    bit has_t, t, lk, used, pulsing;
    has_t = m_good[0] || m_good[1];
    t     = m_good[1];
    m_cyc++;
    case (m_mode)
      M_NOSRC: if (has_t) begin
        move_sel(t);
        m_mode = M_SETTLE;
        m_due  = m_cyc + GAP_LEN;
      end
      M_RUN: begin
        if (!m_good[m_sel] && !has_t) m_mode = M_NOSRC;
        else if (has_t && t != m_sel) begin
          m_next = t;
          m_mode = M_DRAIN;
          m_due  = m_cyc + GAP_LEN;
        end
      end
      M_DRAIN: if (m_cyc == m_due) begin
        move_sel(m_next);
        m_mode = M_SETTLE;
        m_due  = m_cyc + GAP_LEN;
      end
      M_SETTLE: if (m_cyc == m_due) begin
        if (m_good[m_sel]) m_mode = M_RUN;
        else if (has_t) begin
          m_next = t;
          m_mode = M_DRAIN;
          m_due  = m_cyc + GAP_LEN;
        end else m_mode = M_NOSRC;
      end
      default: m_mode = M_NOSRC;
    endcase
    for (int ch = 0; ch < 2; ch++) begin
      lk   = (ch == 1) ? bus.locked_f2 : bus.locked_f1;
      used = m_hist[ch][1];  // raw level from two edges back
      m_hist[ch]     = {m_hist[ch][0], lk};
      m_high_run[ch] = used ? m_high_run[ch] + 1 : 0;
      m_good[ch]     = (m_high_run[ch] >= FILT_LEN);
      pulsing = (m_pulse_left[ch] > 0);
      if (pulsing) m_pulse_left[ch]--;
      if (used) m_low_run[ch] = 0;
      else if (!pulsing) begin
        m_low_run[ch]++;
        if (m_low_run[ch] == RST_TIMEOUT) begin
          m_pulse_left[ch] = RST_PULSE;
          m_low_run[ch]    = 0;
        end
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // ---------------- per-cycle compare ----------------
  logic prev_sel = 1'b0;
  logic prev_en  = 1'b0;

  always @(posedge clk) begin
    #1;
    check("f_select",   bus.f_select,   m_sel);
    check("clk_en",     bus.clk_en,     m_mode == M_RUN);
    check("src_valid",  bus.src_valid,  m_mode == M_RUN);
    check("dcm_rst_f1", bus.dcm_rst_f1, m_pulse_left[0] > 0);
    check("dcm_rst_f2", bus.dcm_rst_f2, m_pulse_left[1] > 0);
    check("switch_cnt", bus.switch_cnt, m_cnt);
    if (rst_n && bus.f_select !== prev_sel) check("en_at_sel_change", prev_en, 1'b0);
    prev_sel = bus.f_select;
    prev_en  = bus.clk_en;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int rise_a [2];
    int rise_b [2];
    int width [2];
    bit prev_r [2];
    bit cur_r [2];
    int en_hi;
    int t;
    bit tgt;
    bit ok;

    bus.locked_f1 = 1'b0;
    bus.locked_f2 = 1'b0;
    tick(3);

    // Power-up with only f2 locking.
    @(negedge clk);
    rst_n = 1'b1;
    bus.locked_f2 = 1'b1;
    check("rst_f_select", bus.f_select, 0);
    check("rst_clk_en", bus.clk_en, 0);
    tick(18);
    check("pu_e18_sel", bus.f_select, 0);
    tick(1);
    check("pu_e19_sel", bus.f_select, 1);
    check("pu_e19_cnt", bus.switch_cnt, 1);
    tick(7);
    check("pu_e26_en", bus.clk_en, 0);
    tick(1);
    check("pu_e27_en", bus.clk_en, 1);
    check("pu_e27_valid", bus.src_valid, 1);

    // f1 comes up, then f2 drops: switch to f1 with 8+8 gap.
    @(negedge clk);
    bus.locked_f1 = 1'b1;
    tick(30);
    @(negedge clk);
    bus.locked_f2 = 1'b0;
    tick(3);
    check("drop_k2_en", bus.clk_en, 1);
    tick(1);
    check("drop_k3_en", bus.clk_en, 0);
    tick(7);
    check("drop_k10_sel", bus.f_select, 1);
    tick(1);
    check("drop_k11_sel", bus.f_select, 0);
    check("drop_k11_en", bus.clk_en, 0);
    tick(7);
    check("drop_k18_en", bus.clk_en, 0);
    tick(1);
    check("drop_k19_en", bus.clk_en, 1);
    check("drop_cnt", bus.switch_cnt, 2);

    // Short f2 flicker while on f1 must not qualify.
    @(negedge clk);
    bus.locked_f2 = 1'b1;
    repeat (10) @(negedge clk);
    bus.locked_f2 = 1'b0;
    tick(30);
    check("flick_sel", bus.f_select, 0);
    check("flick_en", bus.clk_en, 1);
    check("flick_cnt", bus.switch_cnt, 2);

    // Both absent: periodic DCM reset pulses, clock stays disabled.
    @(negedge clk);
    bus.locked_f1 = 1'b0;
    tick(5);
    for (int ch = 0; ch < 2; ch++) begin
      rise_a[ch] = -1;
      rise_b[ch] = -1;
      width[ch]  = 0;
    end
    prev_r[0] = bus.dcm_rst_f1;
    prev_r[1] = bus.dcm_rst_f2;
    en_hi = 0;
    t = 0;
    repeat (2300) begin
      tick(1);
      t++;
      cur_r[0] = bus.dcm_rst_f1;
      cur_r[1] = bus.dcm_rst_f2;
      for (int ch = 0; ch < 2; ch++) begin
        if (cur_r[ch] && !prev_r[ch]) begin
          if (rise_a[ch] < 0) rise_a[ch] = t;
          else if (rise_b[ch] < 0) rise_b[ch] = t;
        end
        if (cur_r[ch] && rise_a[ch] >= 0 && rise_b[ch] < 0) width[ch]++;
        prev_r[ch] = cur_r[ch];
      end
      if (bus.clk_en || bus.src_valid) en_hi++;
    end
    check("f1_rst_period", rise_b[0] - rise_a[0], RST_TIMEOUT + RST_PULSE);
    check("f2_rst_period", rise_b[1] - rise_a[1], RST_TIMEOUT + RST_PULSE);
    check("f1_rst_width", width[0], RST_PULSE);
    check("f2_rst_width", width[1], RST_PULSE);
    check("nosrc_en_cycles", en_hi, 0);

    // Run on f1, start a switch toward f2, reset in the middle of DRAIN.
    @(negedge clk);
    bus.locked_f1 = 1'b1;
    tick(35);
    check("t5_run_f1", bus.clk_en, 1);
    @(negedge clk);
    bus.locked_f2 = 1'b1;
    tick(22);
    check("t5_drain_en", bus.clk_en, 0);
    check("t5_drain_sel", bus.f_select, 0);
    #1 rst_n = 1'b0;
    #1;
    check("t5_rst_cnt", bus.switch_cnt, 0);
    check("t5_rst_en", bus.clk_en, 0);
    check("t5_rst_valid", bus.src_valid, 0);
    check("t5_rst_dcm", {bus.dcm_rst_f1, bus.dcm_rst_f2}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(18);
    check("t5_e18_sel", bus.f_select, 0);
    check("t5_e18_en", bus.clk_en, 0);
    tick(1);
    check("t5_e19_sel", bus.f_select, 1);
    check("t5_e19_cnt", bus.switch_cnt, 1);
    tick(8);
    check("t5_e27_en", bus.clk_en, 1);

    // 300 switchovers by toggling f2 while f1 stays good.
    for (int i = 0; i < 300; i++) begin
      tgt = (i % 2 == 0) ? 1'b0 : 1'b1;
      @(negedge clk);
      bus.locked_f2 = tgt;
      ok = 1'b0;
      for (int w = 0; w < 200 && !ok; w++) begin
        tick(1);
        if (bus.f_select == tgt && bus.clk_en) ok = 1'b1;
      end
      check("t6_switch_done", {bus.f_select, bus.clk_en}, {tgt, 1'b1});
      if (!ok) break;
      if (i == 99) check("t6_cnt_101", bus.switch_cnt, 101);
    end
    check("t6_cnt_sat", bus.switch_cnt, 255);

    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dcm_select_ctrl.md
Name: dcm_select_ctrl

Overview:
- Sequenced clock-source controller for the two-DCM frequency path (f1/f2).
- Replaces the purely combinational lock-to-select mapping with filtered lock detection, a glitch-free switchover sequence for the downstream BUFGMUX/CE mux, and automatic DCM reset retry on prolonged lock loss.
- Sits between the DCM lock outputs and the clock mux select/enable; f2 is the preferred source.

Parameters:
- FILT_LEN, 16: consecutive synchronised-high cycles required before a lock is treated as good.
- GAP_LEN, 8: cycles of clk_en=0 before and after every f_select change.
- RST_TIMEOUT, 1024: consecutive synchronised-low cycles before a DCM reset pulse is issued.
- RST_PULSE, 4: DCM reset pulse width in cycles.

Ports:
- clk  input  1  system clock, independent of both DCM outputs.
- rst_n  input  1  reset, asynchronous, active-low.
- locked_f1  input  1  DCM1 LOCKED, asynchronous to clk.
- locked_f2  input  1  DCM2 LOCKED, asynchronous to clk.
- f_select  output  1  mux select: 0 = f1, 1 = f2.
- clk_en  output  1  enable for the selected clock; low during switchover and while no source is valid.
- src_valid  output  1  high exactly when clk_en is high, i.e. in RUN.
- dcm_rst_f1  output  1  reset pulse to DCM1.
- dcm_rst_f2  output  1  reset pulse to DCM2.
- switch_cnt  output  8  count of f_select changes, saturating at 255.

Behaviour:
- Reset values (asynchronous, on rst_n=0): f_select=0, clk_en=0, src_valid=0, dcm_rst_f1=0, dcm_rst_f2=0, switch_cnt=0. State=NOSRC. All counters cleared. Reset mid-switch aborts the sequence immediately.
- Synchroniser: each locked_x passes through 2 flops, giving 2-edge latency.
- Lock filter, per DCM:
  - lock counter increments while the synchronised lock is high and saturates at FILT_LEN.
  - good_x = (counter == FILT_LEN).
  - A synchronised low clears the counter on that edge, so good_x drops on the same edge.
- Target selection: if good_f2, target = 1; else if good_f1, target = 0; else no target.
- FSM:
  - NOSRC: clk_en=0. When a target exists, f_select <= target on the next edge, then go to SETTLE.
  - RUN: clk_en=1.
    - If good[f_select]=0 and no target exists, go to NOSRC (clk_en=0 from the next edge).
    - Else if target != f_select, latch the target and go to DRAIN.
  - DRAIN: clk_en=0 for GAP_LEN cycles. On the final cycle, f_select <= latched target, then go to SETTLE.
  - SETTLE: clk_en=0 for GAP_LEN cycles. At the end:
    - if good[f_select], go to RUN;
    - else if another target exists, go to DRAIN with the new target;
    - else go to NOSRC.
- Glitch-free guarantee: f_select never changes while clk_en=1. clk_en is registered. f_select changes only on a DRAIN→SETTLE or NOSRC→SETTLE edge.
- Switch counter: switch_cnt increments on every f_select change, including NOSRC→SETTLE when the value changes. It holds at 255.
- Reset retry, per DCM:
  - Unlock counter increments while the synchronised lock is low.
  - On reaching RST_TIMEOUT: assert dcm_rst_x for exactly RST_PULSE cycles and clear the counter. Counting resumes after the pulse ends.
  - Synchronised lock high clears the counter and never truncates an in-progress pulse.
  - The two channels are independent.
- Simultaneous events:
  - Both locks become good on the same edge: target = f2.
  - f2 lock lost in RUN while f1 is good: go to DRAIN toward f1; no NOSRC detour.
  - Lock flickers shorter than FILT_LEN never produce good_x.

Test Plan:
- Power-up, only locked_f2 rises and stays high → good_f2 after edge 18; f_select stays 1-change-free at 0→1 on edge 19; clk_en=1 from edge 27 (±1 for async sampling); switch_cnt=1.
- Both running on f2; drop locked_f2 with f1 good → clk_en low 8 cycles, f_select 1→0, clk_en low 8 more cycles, then high; clk_en never 1 at the f_select edge; switch_cnt=2.
- Pulse locked_f2 high for 10 cycles while on f1 → no switch, clk_en stays 1, switch_cnt unchanged.
- Hold locked_f1 low, f2 absent → both DCMs each get a 4-cycle dcm_rst pulse every 1028 cycles; clk_en=0, src_valid=0 throughout.
- Assert rst_n=0 mid-DRAIN → all outputs return to reset values immediately; after release, the sequence restarts from NOSRC with a full FILT_LEN qualification.
- Toggle sources 300 times → switch_cnt saturates at 255.
